// File: rtl/fp_div_unit.sv
// rtl/fp_div_unit.sv - multi-cycle IEEE-754 single-precision divider with valid/ready handshakes
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   flush                 synchronous abort; the unit returns to idle and drops any result
//   in_valid/in_ready     request handshake carrying a, b (IEEE-754 single) and in_tag
//   out_valid/out_ready   result handshake carrying q = a/b and out_tag
//   flags[4:0]            {NV, DZ, OF, UF, NX}, present only when FP_DIV_FLAGS_EN is defined
//
// Optional feature macro: FP_DIV_FLAGS_EN (adds the flags output).
// Subnormal inputs are treated as zero and subnormal results are flushed to zero.

module fp_div_unit #(
    parameter int BITS_PER_CYCLE = 1,
    parameter int TAG_W          = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      q,
`ifdef FP_DIV_FLAGS_EN
    output logic [4:0]       flags,
`endif
    output logic [TAG_W-1:0] out_tag
);

    // 24 mantissa bits plus guard and round bits
    localparam int N_ITER = (26 + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DIV   = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic              sign_r;
    logic signed [9:0] exp_r;
    logic [23:0]       div_r;
    logic [25:0]       rem_r;
    logic [25:0]       quo_r;
    logic [4:0]        cnt_r;

    assign in_ready = (state == S_IDLE);

    // Operand classification and special-case results
    logic [7:0]  ea, eb;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic        sign_in, sp_hit;
    logic [31:0] sp_q;
    logic [4:0]  sp_flags;

    always_comb begin
        ea       = a[30:23];
        eb       = b[30:23];
        a_zero   = (ea == 8'h00);
        b_zero   = (eb == 8'h00);
        a_inf    = (ea == 8'hFF) && (a[22:0] == 23'd0);
        b_inf    = (eb == 8'hFF) && (b[22:0] == 23'd0);
        a_nan    = (ea == 8'hFF) && (a[22:0] != 23'd0);
        b_nan    = (eb == 8'hFF) && (b[22:0] != 23'd0);
        sign_in  = a[31] ^ b[31];
        sp_hit   = 1'b1;
        sp_q     = 32'd0;
        sp_flags = 5'd0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            sp_q     = 32'h7FC0_0000;
            sp_flags = 5'b10000;
        end else if (a_inf) begin
            sp_q = {sign_in, 8'hFF, 23'd0};
        end else if (b_zero) begin
            sp_q     = {sign_in, 8'hFF, 23'd0};
            sp_flags = 5'b01000;
        end else if (b_inf || a_zero) begin
            sp_q = {sign_in, 31'd0};
        end else begin
            sp_hit = 1'b0;
        end
    end

    // Restoring division step(s); remainder stays below twice the divisor
    logic [25:0] rem_n, quo_n;

    always_comb begin
        rem_n = rem_r;
        quo_n = quo_r;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (rem_n >= {2'b00, div_r}) begin
                rem_n = rem_n - {2'b00, div_r};
                quo_n = {quo_n[24:0], 1'b1};
            end else begin
                quo_n = {quo_n[24:0], 1'b0};
            end
            rem_n = {rem_n[24:0], 1'b0};
        end
    end

    // Normalise, round to nearest even, range check
    logic [23:0]       mant;
    logic              guard, sticky, round_up;
    logic signed [9:0] e_norm, e_fin;
    logic [24:0]       mant_rnd;
    logic [22:0]       mant_fin;
    logic [31:0]       rnd_q;
    logic [4:0]        rnd_flags;

    always_comb begin
        if (quo_r[25]) begin
            mant   = quo_r[25:2];
            guard  = quo_r[1];
            sticky = quo_r[0] | (rem_r != 26'd0);
            e_norm = exp_r;
        end else begin
            mant   = quo_r[24:1];
            guard  = quo_r[0];
            sticky = (rem_r != 26'd0);
            e_norm = exp_r - 10'sd1;
        end
        round_up = guard & (sticky | mant[0]);
        mant_rnd = {1'b0, mant} + {24'd0, round_up};
        // A carry out of the mantissa leaves 1.000..0, so only the exponent moves
        if (mant_rnd[24]) begin
            mant_fin = mant_rnd[23:1];
            e_fin    = e_norm + 10'sd1;
        end else begin
            mant_fin = mant_rnd[22:0];
            e_fin    = e_norm;
        end
        rnd_flags = {4'b0000, guard | sticky};
        if (e_fin >= 10'sd255) begin
            rnd_q     = {sign_r, 8'hFF, 23'd0};
            rnd_flags = 5'b00101;
        end else if (e_fin <= 10'sd0) begin
            rnd_q     = {sign_r, 31'd0};
            rnd_flags = 5'b00011;
        end else begin
            rnd_q = {sign_r, e_fin[7:0], mant_fin};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            q         <= 32'd0;
            out_tag   <= '0;
            sign_r    <= 1'b0;
            exp_r     <= 10'sd0;
            div_r     <= 24'd0;
            rem_r     <= 26'd0;
            quo_r     <= 26'd0;
            cnt_r     <= 5'd0;
`ifdef FP_DIV_FLAGS_EN
            flags     <= 5'd0;
`endif
        end else if (flush) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
`ifdef FP_DIV_FLAGS_EN
            flags     <= 5'd0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        out_tag <= in_tag;
                        sign_r  <= sign_in;
                        if (sp_hit) begin
                            q         <= sp_q;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
`ifdef FP_DIV_FLAGS_EN
                            flags     <= sp_flags;
`endif
                        end else begin
                            exp_r <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
                            div_r <= {1'b1, b[22:0]};
                            rem_r <= {3'b001, a[22:0]};
                            quo_r <= 26'd0;
                            cnt_r <= 5'd0;
                            state <= S_DIV;
                        end
                    end
                end
                S_DIV: begin
                    rem_r <= rem_n;
                    quo_r <= quo_n;
                    cnt_r <= cnt_r + 5'd1;
                    if (cnt_r == 5'(N_ITER - 1)) begin
                        state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    q         <= rnd_q;
                    out_valid <= 1'b1;
                    state     <= S_DONE;
`ifdef FP_DIV_FLAGS_EN
                    flags     <= rnd_flags;
`endif
                end
                default: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

`ifndef FP_DIV_FLAGS_EN
    // Flag terms are only consumed when the flags port exists
    logic unused_flags;
    assign unused_flags = ^{sp_flags, rnd_flags};
`endif

endmodule

// File: tb/tb_fp_div_unit.sv
// tb/tb_fp_div_unit.sv - self-checking bench for fp_div_unit

module tb_fp_div_unit;

    localparam int TAG_W = 5;
    localparam int LAT1  = 26 + 2;
    localparam int LAT2  = 13 + 2;

    logic             clk, rst_n, flush;
    logic             in_valid, in_ready, out_valid, out_ready;
    logic [31:0]      a, b, q;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic             in_valid2, in_ready2, out_valid2;
    logic [31:0]      q2;
    logic [TAG_W-1:0] out_tag2;
`ifdef FP_DIV_FLAGS_EN
    logic [4:0]       flags, flags2;
`endif

    int checks   = 0;
    int failures = 0;

    fp_div_unit #(.BITS_PER_CYCLE(1), .TAG_W(TAG_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .q(q),
`ifdef FP_DIV_FLAGS_EN
        .flags(flags),
`endif
        .out_tag(out_tag)
    );

    fp_div_unit #(.BITS_PER_CYCLE(2), .TAG_W(TAG_W)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid2), .in_ready(in_ready2), .a(a), .b(b), .in_tag(in_tag),
        .out_valid(out_valid2), .out_ready(1'b1), .q(q2),
`ifdef FP_DIV_FLAGS_EN
        .flags(flags2),
`endif
        .out_tag(out_tag2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference divider: wide integer quotient of the significands, then RNE
    function automatic void model_div(input logic [31:0] x, input logic [31:0] y,
                                      output logic [31:0] rq, output logic [4:0] rf);
        int ex, ey, e;
        logic s;
        logic xz, yz, xi, yi, xn, yn;
        longint unsigned mx, my, num, qq, rem, m, low, half;
        logic up, inx;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        s  = x[31] ^ y[31];
        xz = (ex == 0);
        yz = (ey == 0);
        xi = (ex == 255) && (x[22:0] == 0);
        yi = (ey == 255) && (y[22:0] == 0);
        xn = (ex == 255) && (x[22:0] != 0);
        yn = (ey == 255) && (y[22:0] != 0);
        rf = 5'd0;
        if (xn || yn || (xz && yz) || (xi && yi)) begin
            rq = 32'h7FC00000; rf = 5'b10000;
        end else if (xi) begin
            rq = {s, 8'hFF, 23'd0};
        end else if (yz) begin
            rq = {s, 8'hFF, 23'd0}; rf = 5'b01000;
        end else if (yi || xz) begin
            rq = {s, 31'd0};
        end else begin
            mx  = 64'(x[22:0]) + 64'h800000;
            my  = 64'(y[22:0]) + 64'h800000;
            e   = ex - ey + 127;
            num = mx << 26;
            qq  = num / my;
            rem = num % my;
            if (qq >= (64'd1 << 26)) begin
                m = qq >> 3; low = qq & 7; half = 4;
            end else begin
                e = e - 1; m = qq >> 2; low = qq & 3; half = 2;
            end
            inx = (low != 0) || (rem != 0);
            up  = (low > half) || ((low == half) && ((rem != 0) || ((m & 1) != 0)));
            m   = m + (up ? 1 : 0);
            if (m == (64'd1 << 24)) begin
                m = m >> 1; e = e + 1;
            end
            if (e >= 255) begin
                rq = {s, 8'hFF, 23'd0}; rf = 5'b00101;
            end else if (e <= 0) begin
                rq = {s, 31'd0}; rf = 5'b00011;
            end else begin
                rq = {s, 8'(e), 23'(m)}; rf = {4'd0, inx};
            end
        end
    endfunction

    // Scoreboard of expected results, maintained from the observed handshakes
    logic [31:0]      exp_q[$];
    logic [4:0]       exp_f[$];
    logic [TAG_W-1:0] exp_t[$];
    logic [31:0]      mon_q;
    logic [4:0]       mon_f;

    always @(posedge clk) begin
        if (!rst_n || flush) begin
            exp_q.delete(); exp_f.delete(); exp_t.delete();
        end else begin
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front()); void'(exp_f.pop_front()); void'(exp_t.pop_front());
            end
            if (in_valid && in_ready) begin
                model_div(a, b, mon_q, mon_f);
                exp_q.push_back(mon_q); exp_f.push_back(mon_f); exp_t.push_back(in_tag);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out_valid actual=1 expected=0");
            end else begin
                check("q", q, exp_q[0]);
                check("out_tag", 32'(out_tag), 32'(exp_t[0]));
`ifdef FP_DIV_FLAGS_EN
                check("flags", 32'(flags), 32'(exp_f[0]));
`endif
            end
        end
    end

    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [TAG_W-1:0] tag,
                          input logic [31:0] eq, input logic [4:0] ef, input int el);
        logic [31:0] mq;
        logic [4:0]  mf;
        int lat;
        model_div(x, y, mq, mf);
        check("model_q", mq, eq);
        check("model_flags", 32'(mf), 32'(ef));
        @(negedge clk);
        a = x; b = y; in_tag = tag; in_valid = 1'b1; out_ready = 1'b1;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(el));
        @(posedge clk);
    endtask

    initial begin
        int lat, cnt;
        logic [31:0] held_q;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0;
        out_ready = 1'b1; a = 32'd0; b = 32'd0; in_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_q", q, 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(32'h40C00000, 32'h40400000, 5'd3,  32'h40000000, 5'b00000, LAT1);
        run_op(32'h3F800000, 32'h40400000, 5'd7,  32'h3EAAAAAB, 5'b00001, LAT1);
        run_op(32'h3F800000, 32'h00000000, 5'd1,  32'h7F800000, 5'b01000, 1);
        run_op(32'h00000000, 32'h00000000, 5'd2,  32'h7FC00000, 5'b10000, 1);
        run_op(32'hFF800000, 32'h40000000, 5'd4,  32'hFF800000, 5'b00000, 1);
        run_op(32'h7F7FFFFF, 32'h3E800000, 5'd5,  32'h7F800000, 5'b00101, LAT1);
        run_op(32'h00800000, 32'h4B000000, 5'd6,  32'h00000000, 5'b00011, LAT1);
        run_op(32'hC0C00000, 32'h40400000, 5'd8,  32'hC0000000, 5'b00000, LAT1);
        run_op(32'h40E00000, 32'h40000000, 5'd10, 32'h40600000, 5'b00000, LAT1);
        run_op(32'h7FC00001, 32'h3F800000, 5'd11, 32'h7FC00000, 5'b10000, 1);
        run_op(32'h40000000, 32'h7F800000, 5'd12, 32'h00000000, 5'b00000, 1);
        run_op(32'h00000001, 32'hBF800000, 5'd13, 32'h80000000, 5'b00000, 1);
        run_op(32'h40000000, 32'h40400000, 5'd14, 32'h3F2AAAAB, 5'b00001, LAT1);
        run_op(32'h3F800000, 32'h80000001, 5'd15, 32'hFF800000, 5'b01000, 1);
        run_op(32'h7F800000, 32'hFF800000, 5'd16, 32'h7FC00000, 5'b10000, 1);

        // Backpressure: result held in DONE, a second request must wait
        @(negedge clk);
        a = 32'h40C00000; b = 32'h40400000; in_tag = 5'd20; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a = 32'h3F800000; b = 32'h40400000; in_tag = 5'd21;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("bp_latency", 32'(lat), 32'(LAT1));
        held_q = q;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_q_stable", q, held_q);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_idle", 32'(in_ready), 32'd1);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("bp_second_accept", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("bp_second_latency", 32'(lat), 32'(LAT1));
        check("bp_second_q", q, 32'h3EAAAAAB);
        @(posedge clk);

        // Flush in the middle of DIV together with a competing request
        @(negedge clk);
        a = 32'h40C00000; b = 32'h40400000; in_tag = 5'd9; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; a = 32'h3F800000; b = 32'h40400000;
        @(posedge clk);
        @(negedge clk);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        flush = 1'b0; in_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("flush_no_result", 32'(cnt), 32'd0);

        // Asynchronous reset in the middle of DIV
        @(negedge clk);
        a = 32'h40C00000; b = 32'h40400000; in_tag = 5'd9; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_q", q, 32'd0);
        check("arst_out_tag", 32'(out_tag), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'h40C00000, 32'h40400000, 5'd3, 32'h40000000, 5'b00000, LAT1);

        // Two bits per cycle: same quotient, shorter latency
        @(negedge clk);
        a = 32'h3F800000; b = 32'h40400000; in_tag = 5'd17; in_valid2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid2 = 1'b0;
        lat = 1;
        while (!out_valid2 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("bpc2_latency", 32'(lat), 32'(LAT2));
        check("bpc2_q", q2, 32'h3EAAAAAB);
        check("bpc2_out_tag", 32'(out_tag2), 32'd17);
`ifdef FP_DIV_FLAGS_EN
        check("bpc2_flags", 32'(flags2), 32'd1);
`endif
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
